if_stage: RTL
=============

# if_stage

Fetch stage of the five-stage MIPS pipeline, between the pre-fetch (request) stage and decode. Holds one fetched PC and completes its instruction from the inst SRAM-like `data_ok` response, or takes the instruction already captured upstream. Raises fetch address-error exceptions and forwards `{ex, excode, inst, pc}` to decode. On a writeback flush it drops stale in-flight responses so neither fetch stage takes a wrong instruction.

## Interface
Parameters: none. Widths come from `mycpu.h`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `pfs_to_fs_valid`  in  1  pre-fetch has a PC (and maybe an instruction) to hand over
- `pfs_to_fs_bus`  in  65  [64] inst_ok, [63:32] inst, [31:0] pc
- `pfs_inst_waiting`  in  1  pre-fetch has an accepted address whose data has not yet been delivered to it
- `fs_allowin`  out  1  fetch can load this cycle
- `fs_valid`  out  1  fetch holds a live entry
- `fs_inst_unable`  out  1  fetch will not consume this cycle's `data_ok`; pre-fetch may take it
- `inst_sram_data_ok`  in  1  response strobe
- `inst_sram_rdata`  in  32  response data
- `ds_allowin`  in  1  decode can accept
- `fs_to_ds_valid`  out  1  entry leaving to decode
- `fs_to_ds_bus`  out  70  [69] ex, [68:64] excode, [63:32] inst, [31:0] pc
- `ws_ex`, `ws_eret`  in  1 each  flush strobes from writeback

## Operation
- Registers:
  - `fs_valid`
  - `fs_pc[31:0]`
  - `buf_valid`, `buf_inst[31:0]`
  - `cancel_cnt[1:0]`, the number of outstanding responses to discard
- `flush = ws_ex | ws_eret`.
- `fs_wait = fs_valid & ~buf_valid`.
- `take_data = inst_sram_data_ok & (cancel_cnt == 0) & fs_wait`.
- `fs_ready_go = buf_valid | take_data`.
- `fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin)`.
- `fs_to_ds_valid = fs_valid & fs_ready_go & ~flush`.
- Output inst is `buf_valid ? buf_inst : inst_sram_rdata`.
- `fs_inst_unable = (cancel_cnt == 0) & ~fs_wait`.
- Load: on `fs_allowin`, set `fs_valid <= pfs_to_fs_valid & ~flush`, `fs_pc <= bus.pc`, `buf_valid <= bus.inst_ok`, `buf_inst <= bus.inst`.
- Capture: on `take_data` without a load, set `buf_valid <= 1` and `buf_inst <= rdata`. This covers data that returns while decode stalls.
- Flush has priority over load and capture. At the next edge, `fs_valid = 0` and `buf_valid = 0`.
- Cancel counter:
  - Flush cycle: `cancel_cnt <= cancel_cnt + fs_wait + pfs_inst_waiting − (inst_sram_data_ok & (cancel_cnt != 0 | fs_wait))`.
  - Otherwise: decrement on `inst_sram_data_ok` when nonzero.
  - Maximum legal value is 2. A value of 3 is a checker error.
- Exception: when `fs_pc[1:0] != 0`, set ex=1, excode=`EXCODE_ADEL` (5'h04), inst field forced to 0. The response is still awaited and discarded; the bad PC is carried in the pc field as BadVAddr.

## Timing
- Reset values: `fs_valid=0`, `fs_to_ds_valid=0`, `fs_allowin=1`, `fs_inst_unable=1`, `cancel_cnt=0`, `buf_valid=0`, bus=0.
- Pass-through latency is 1 cycle when the instruction arrives with inst_ok.
- Otherwise the entry leaves in the same cycle as `take_data`, or in any later cycle once decode allows in.
- A response while `cancel_cnt != 0` is dropped by both stages. A new entry loaded during cancel waits until the count reaches 0.
- A flush in the same cycle as `take_data` discards that data, and the data is not counted.
- Flush during reset: reset wins.

## Structure
- `mycpu.h` gains `FS_TO_DS_BUS_WD` (70) and `EXCODE_ADEL`, and reuses `PFS_TO_FS_BUS_WD` (65).
- No sub-module. The cancel counter and buffer live inline.

## Test plan
- Reset 2 cycles: all outputs at their reset values. `fs_allowin=1`, `fs_inst_unable=1`.
- Load pc=0xbfc00000 with inst_ok=1, inst=0x24010001, `ds_allowin=1`: `fs_to_ds_valid=1` the next cycle with bus {0, 0, 0x24010001, 0xbfc00000}.
- Load with inst_ok=0, then `data_ok` after 3 cycles with rdata=0x8c220000:
  - `fs_inst_unable=0` while waiting.
  - `fs_to_ds_valid` rises in the `data_ok` cycle.
- Hold `ds_allowin=0` while `data_ok` arrives: `buf_valid=1`. On release, the instruction is issued once and `fs_allowin=1` in the same cycle.
- Flush with `fs_wait=1` and `pfs_inst_waiting=1`:
  - `cancel_cnt=2`.
  - The next two `data_ok` are ignored with `fs_inst_unable=0`.
  - A third `data_ok` completes the new entry.
- Load pc=0xbfc00002: output ex=1, excode=0x04, inst=0, pc=0xbfc00002 after its response.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch/decode bundle types and constants.
// Imported by the fetch stage and its neighbours.
package if_stage_pkg;

  localparam int PFS_TO_FS_BUS_WD = 65;
  localparam int FS_TO_DS_BUS_WD  = 70;

  localparam logic [4:0] EXCODE_ADEL = 5'h04;

  typedef struct packed {
    logic        inst_ok;
    logic [31:0] inst;
    logic [31:0] pc;
  } pfs_to_fs_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage.sv
// Fetch stage: holds one PC, completes it from the inst
// response or the upstream capture, drops flushed responses.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pfs_to_fs_valid,
  input  logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
  input  logic                        pfs_inst_waiting,
  output logic                        fs_allowin,
  output logic                        fs_valid,
  output logic                        fs_inst_unable,
  input  logic                        inst_sram_data_ok,
  input  logic [31:0]                 inst_sram_rdata,
  input  logic                        ds_allowin,
  output logic                        fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
  input  logic                        ws_ex,
  input  logic                        ws_eret
);

  pfs_to_fs_t pfs;
  fs_to_ds_t  ds;

  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [1:0]  cancel_cnt;
  logic [1:0]  cancel_nxt;

  logic flush;
  logic fs_wait;
  logic cnt_zero;
  logic take_data;
  logic fs_ready_go;
  logic adel;
  logic drop_sub;

  assign pfs = pfs_to_fs_t'(pfs_to_fs_bus);

  assign flush       = ws_ex | ws_eret;
  assign fs_wait     = fs_valid & ~buf_valid;
  assign cnt_zero    = (cancel_cnt == 2'd0);
  assign take_data   = inst_sram_data_ok & cnt_zero & fs_wait;
  assign fs_ready_go = buf_valid | take_data;

  assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~flush;
  assign fs_inst_unable = cnt_zero & ~fs_wait;

  assign adel = (fs_pc[1:0] != 2'b00);

  // Bus to decode; zero when no live entry.
  always_comb begin
    ds        = '0;
    if (fs_valid) begin
      ds.ex     = adel;
      ds.excode = adel ? EXCODE_ADEL : 5'h00;
      ds.inst   = adel ? 32'h0
                : (buf_valid ? buf_inst : inst_sram_rdata);
      ds.pc     = fs_pc;
    end
  end

  assign fs_to_ds_bus = ds;

  // Entry register: flush beats load beats capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      fs_pc     <= '0;
      buf_valid <= 1'b0;
      buf_inst  <= '0;
    end else if (flush) begin
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid  <= pfs_to_fs_valid;
      fs_pc     <= pfs.pc;
      buf_valid <= pfs.inst_ok;
      buf_inst  <= pfs.inst;
    end else if (take_data) begin
      buf_valid <= 1'b1;
      buf_inst  <= inst_sram_rdata;
    end
  end

  // Responses owed to flushed requests, net of one arriving now.
  always_comb begin
    drop_sub   = inst_sram_data_ok & (~cnt_zero | fs_wait);
    cancel_nxt = cancel_cnt;
    if (flush)
      cancel_nxt = cancel_cnt
                 + {1'b0, fs_wait}
                 + {1'b0, pfs_inst_waiting}
                 - {1'b0, drop_sub};
    else if (inst_sram_data_ok & ~cnt_zero)
      cancel_nxt = cancel_cnt - 2'd1;
  end

  // Cancel counter register.
  always_ff @(posedge clk) begin
    if (reset) cancel_cnt <= 2'd0;
    else       cancel_cnt <= cancel_nxt;
  end

endmodule
